// File: rtl/instr_fetch_buffer.sv
// Fetch stage: issues word reads, queues returned instructions with their PCs, flushes on redirect.
// Optional FETCH_PERF_EN adds saturating starvation and flush counters.
module instr_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
`ifdef FETCH_PERF_EN
  output logic [31:0] out_pc,
  output logic [31:0] perf_starve_cnt,
  output logic [31:0] perf_flush_cnt
`else
  output logic [31:0] out_pc
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
  localparam logic [31:0] PC_STEP = 32'h0000_0004;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [31:0]       fetch_pc_r, fetch_pc_s;
  logic              discard_r, discard_s;
  logic              mem_req_valid_r, req_valid_s;
  logic [31:0]       mem_req_addr_r, req_addr_s;
  logic [CNT_W-1:0]  count_r, count_s;
  logic [PTR_W-1:0]  rd_ptr_r, rd_ptr_s;
  logic [PTR_W-1:0]  wr_ptr_r, wr_ptr_s;
  logic [31:0]       instr_mem_r [DEPTH];
  logic [31:0]       pc_mem_r [DEPTH];
  logic              out_valid_r, head_valid_s;
  logic [31:0]       out_instr_r, head_instr_s;
  logic [31:0]       out_pc_r, head_pc_s;
  logic              handshake_s, push_s, pop_s;
  logic [31:0]       redir_pc_s;
  logic              redirect_lsb_unused_s;

  assign handshake_s = mem_req_valid_r && mem_req_ready;
  assign redir_pc_s  = {redirect_pc[31:2], 2'b00};
  assign redirect_lsb_unused_s = ^redirect_pc[1:0];

  assign mem_req_valid = mem_req_valid_r;
  assign mem_req_addr  = mem_req_addr_r;
  assign out_valid     = out_valid_r;
  assign out_instr     = out_instr_r;
  assign out_pc        = out_pc_r;

  // Fetch FSM next state, request outputs and push decision
  always_comb begin
    state_s     = state_r;
    fetch_pc_s  = fetch_pc_r;
    discard_s   = discard_r;
    req_valid_s = mem_req_valid_r;
    req_addr_s  = mem_req_addr_r;
    push_s      = 1'b0;
    case (state_r)
      IDLE: begin
        // Only IDLE issues, so no response is outstanding and count alone is the credit check
        if (redirect_valid) begin
          fetch_pc_s = redir_pc_s;
        end else if (count_r < DEPTH_C) begin
          state_s     = REQ;
          req_valid_s = 1'b1;
          req_addr_s  = fetch_pc_r;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (handshake_s) begin
          state_s     = WAIT;
          req_valid_s = 1'b0;
          if (redirect_valid) begin
            discard_s  = 1'b1;
            fetch_pc_s = redir_pc_s;
          end else begin
            fetch_pc_s = fetch_pc_r + PC_STEP;
          end
        end else if (redirect_valid) begin
          state_s     = IDLE;
          req_valid_s = 1'b0;
          fetch_pc_s  = redir_pc_s;
        end else begin
          req_valid_s = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_s   = IDLE;
          discard_s = 1'b0;
          push_s    = !discard_r && !redirect_valid;
          if (redirect_valid) begin
            fetch_pc_s = redir_pc_s;
          end else begin
            fetch_pc_s = fetch_pc_r;
          end
        end else if (redirect_valid) begin
          discard_s  = 1'b1;
          fetch_pc_s = redir_pc_s;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s     = IDLE;
        req_valid_s = 1'b0;
        discard_s   = 1'b0;
      end
    endcase
  end

  // FIFO pointer and occupancy update; a redirect voids push and pop
  always_comb begin
    pop_s    = (count_r != '0) && out_ready && !redirect_valid;
    count_s  = count_r;
    rd_ptr_s = rd_ptr_r;
    wr_ptr_s = wr_ptr_r;
    if (redirect_valid) begin
      count_s  = '0;
      rd_ptr_s = '0;
      wr_ptr_s = '0;
    end else begin
      if (pop_s) begin
        rd_ptr_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      if (push_s) begin
        wr_ptr_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_s = count_r + CNT_ONE;
        2'b01:   count_s = count_r - CNT_ONE;
        default: count_s = count_r;
      endcase
    end
  end

  // Next head of queue, bypassing the entry being written when it becomes the head
  always_comb begin
    head_valid_s = (count_s != '0);
    head_instr_s = 32'h0000_0000;
    head_pc_s    = 32'h0000_0000;
    if (!head_valid_s) begin
      head_instr_s = 32'h0000_0000;
      head_pc_s    = 32'h0000_0000;
    end else if (push_s && (rd_ptr_s == wr_ptr_r)) begin
      head_instr_s = mem_rsp_data;
      head_pc_s    = mem_req_addr_r;
    end else begin
      head_instr_s = instr_mem_r[rd_ptr_s];
      head_pc_s    = pc_mem_r[rd_ptr_s];
    end
  end

  // Control state, request outputs and registered head
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r         <= IDLE;
      fetch_pc_r      <= {RESET_PC[31:2], 2'b00};
      discard_r       <= 1'b0;
      mem_req_valid_r <= 1'b0;
      mem_req_addr_r  <= 32'h0000_0000;
      count_r         <= '0;
      rd_ptr_r        <= '0;
      wr_ptr_r        <= '0;
      out_valid_r     <= 1'b0;
      out_instr_r     <= 32'h0000_0000;
      out_pc_r        <= 32'h0000_0000;
    end else begin
      state_r         <= state_s;
      fetch_pc_r      <= fetch_pc_s;
      discard_r       <= discard_s;
      mem_req_valid_r <= req_valid_s;
      mem_req_addr_r  <= req_addr_s;
      count_r         <= count_s;
      rd_ptr_r        <= rd_ptr_s;
      wr_ptr_r        <= wr_ptr_s;
      out_valid_r     <= head_valid_s;
      out_instr_r     <= head_instr_s;
      out_pc_r        <= head_pc_s;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]    <= 32'h0000_0000;
      end
    end else if (push_s) begin
      instr_mem_r[wr_ptr_r] <= mem_rsp_data;
      pc_mem_r[wr_ptr_r]    <= mem_req_addr_r;
    end else begin
      instr_mem_r[wr_ptr_r] <= instr_mem_r[wr_ptr_r];
      pc_mem_r[wr_ptr_r]    <= pc_mem_r[wr_ptr_r];
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_starve_r;
  logic [31:0] perf_flush_r;

  assign perf_starve_cnt = perf_starve_r;
  assign perf_flush_cnt  = perf_flush_r;

  // Saturating starvation and flush counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_starve_r <= 32'h0000_0000;
      perf_flush_r  <= 32'h0000_0000;
    end else begin
      if (out_ready && !out_valid_r && (perf_starve_r != 32'hFFFF_FFFF)) begin
        perf_starve_r <= perf_starve_r + 32'h0000_0001;
      end else begin
        perf_starve_r <= perf_starve_r;
      end
      if (redirect_valid && (perf_flush_r != 32'hFFFF_FFFF)) begin
        perf_flush_r <= perf_flush_r + 32'h0000_0001;
      end else begin
        perf_flush_r <= perf_flush_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer (RESET_PC=0x100, DEPTH=4) with a 1-cycle-response memory model.
module tb_instr_fetch_buffer;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_starve_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic        rsp_pending;
  logic        rsp_hold;
  logic [31:0] rsp_addr;
  logic [31:0] req_log[$];
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_instr_log[$];

  instr_fetch_buffer #(.RESET_PC(32'h0000_0100), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
`ifdef FETCH_PERF_EN
    .out_pc         (out_pc),
    .perf_starve_cnt(perf_starve_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`else
    .out_pc         (out_pc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'h0050_0093 : a + 32'h1000_0000;
  endfunction

  assign mem_rsp_valid = rsp_pending && !rsp_hold;
  assign mem_rsp_data  = mem_rsp_valid ? instr_of(rsp_addr) : 32'h0000_0000;

  // One clock: note handshakes before the edge, update the memory model after it
  task automatic tick();
    logic        hs, popd, delivered, rst_pre;
    logic [31:0] ha, pp, pi;
    hs        = mem_req_valid && mem_req_ready;
    ha        = mem_req_addr;
    popd      = out_valid && out_ready && !redirect_valid;
    pp        = out_pc;
    pi        = out_instr;
    delivered = mem_rsp_valid;
    rst_pre   = rst;
    @(posedge clk);
    @(negedge clk);
    if (!rst_pre) begin
      rsp_pending = 1'b0;
    end else begin
      if (delivered) rsp_pending = 1'b0;
      if (hs) begin
        rsp_pending = 1'b1;
        rsp_addr    = ha;
        req_log.push_back(ha);
      end
      if (popd) begin
        pop_pc_log.push_back(pp);
        pop_instr_log.push_back(pi);
      end
    end
  endtask

  task automatic wait_reqs(input int target, output bit ok);
    for (int i = 0; i < 40 && req_log.size() < target; i++) tick();
    ok = (req_log.size() >= target);
  endtask

  task automatic wait_pops(input int target, output bit ok);
    for (int i = 0; i < 40 && pop_pc_log.size() < target; i++) tick();
    ok = (pop_pc_log.size() >= target);
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_pc_log.delete();
    pop_instr_log.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %0b expected 0", mem_req_valid); end
    n_checks++; if (mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h expected 0", mem_req_addr); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h expected 0", out_instr); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
    clear_logs();
  endtask

  task automatic test_single_fetch();
    rst = 1'b1;
    tick();
    n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid: got %0b expected 1", mem_req_valid); end
    n_checks++; if (mem_req_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL first_req_addr: got %h expected 00000100", mem_req_addr); end
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid: got %0b expected 1", out_valid); end
    n_checks++; if (out_instr !== 32'h0050_0093) begin n_fail++; $display("FAIL single_out_instr: got %h expected 00500093", out_instr); end
    n_checks++; if (out_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL single_out_pc: got %h expected 00000100", out_pc); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_addr [4];
    exp_addr = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108, 32'h0000_010C};
    repeat (20) tick();
    n_checks++; if (req_log.size() != 4) begin n_fail++; $display("FAIL full_req_count: got %0d expected 4", req_log.size()); end
    n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_no_req: got %0b expected 0", mem_req_valid); end
    n_checks++; if (out_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL full_head_pc: got %h expected 00000100", out_pc); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (req_log[i] !== exp_addr[i]) begin n_fail++; $display("FAIL full_req_addr[%0d]: got %h expected %h", i, req_log[i], exp_addr[i]); end
    end
    out_ready = 1'b1;
    repeat (16) tick();
    n_checks++; if (pop_pc_log.size() < 5) begin n_fail++; $display("FAIL drain_pop_count: got %0d expected >=5", pop_pc_log.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (pop_pc_log[i] !== exp_addr[i]) begin n_fail++; $display("FAIL drain_pop_pc[%0d]: got %h expected %h", i, pop_pc_log[i], exp_addr[i]); end
    end
    n_checks++; if (pop_instr_log[0] !== 32'h0050_0093) begin n_fail++; $display("FAIL drain_instr0: got %h expected 00500093", pop_instr_log[0]); end
    n_checks++; if (pop_instr_log[3] !== 32'h1000_010C) begin n_fail++; $display("FAIL drain_instr3: got %h expected 1000010c", pop_instr_log[3]); end
    n_checks++; if (req_log[4] !== 32'h0000_0110) begin n_fail++; $display("FAIL resume_req: got %h expected 00000110", req_log[4]); end
    n_checks++; if (pop_pc_log[4] !== 32'h0000_0110) begin n_fail++; $display("FAIL resume_pop: got %h expected 00000110", pop_pc_log[4]); end
  endtask

  task automatic test_redirect_wait();
    bit found;
    rst = 1'b0;
    rsp_hold = 1'b0;
    repeat (2) tick();
    clear_logs();
    rst = 1'b1;
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mem_req_valid && mem_req_addr == 32'h0000_0108) found = 1'b1;
      else tick();
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rw_req108 timeout: got no request expected 00000108"); end
    rsp_hold = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rw_flush_empty: got %0b expected 0", out_valid); end
    rsp_hold = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rw_rsp_dropped: got %0b expected 0", out_valid); end
    tick();
    n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_0200) begin n_fail++; $display("FAIL rw_next_req: got %0b/%h expected 1/00000200", mem_req_valid, mem_req_addr); end
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_0200) begin n_fail++; $display("FAIL rw_first_out: got %0b/%h expected 1/00000200", out_valid, out_pc); end
  endtask

  task automatic test_misaligned_wrap();
    int n0, p0;
    bit ok;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    n0 = req_log.size();
    p0 = pop_pc_log.size();
    wait_reqs(n0 + 1, ok);
    n_checks++; if (!ok || req_log[n0] !== 32'h0000_0200) begin n_fail++; $display("FAIL misaligned_req: got %h expected 00000200", req_log[n0]); end
    wait_pops(p0 + 1, ok);
    n_checks++; if (!ok || pop_pc_log[p0] !== 32'h0000_0200) begin n_fail++; $display("FAIL misaligned_pop: got %h expected 00000200", pop_pc_log[p0]); end

    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    n0 = req_log.size();
    p0 = pop_pc_log.size();
    wait_reqs(n0 + 2, ok);
    n_checks++; if (!ok || req_log[n0] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req0: got %h expected fffffffc", req_log[n0]); end
    n_checks++; if (!ok || req_log[n0 + 1] !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_req1: got %h expected 00000000", req_log[n0 + 1]); end
    wait_pops(p0 + 2, ok);
    n_checks++; if (!ok || pop_pc_log[p0] !== 32'hFFFF_FFFC || pop_pc_log[p0 + 1] !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pops: got %h,%h expected fffffffc,00000000", pop_pc_log[p0], pop_pc_log[p0 + 1]); end
    n_checks++; if (!ok || pop_instr_log[p0 + 1] !== 32'h1000_0000) begin n_fail++; $display("FAIL wrap_instr: got %h expected 10000000", pop_instr_log[p0 + 1]); end
  endtask

  task automatic test_simultaneous();
    int n0;
    bit ok;
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    n0 = req_log.size();
    wait_reqs(n0 + 3, ok);
    n_checks++; if (!ok || req_log[n0 + 2] !== 32'h0000_0308) begin n_fail++; $display("FAIL sim_setup_req: got %h expected 00000308", req_log[n0 + 2]); end
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_0300) begin n_fail++; $display("FAIL sim_setup_head: got %0b/%h expected 1/00000300", out_valid, out_pc); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0400;
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sim_flush: got %0b expected 0", out_valid); end
    tick();
    n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_0400) begin n_fail++; $display("FAIL sim_next_req: got %0b/%h expected 1/00000400", mem_req_valid, mem_req_addr); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sim_no_early_out: got %0b expected 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_0400 || out_instr !== 32'h1000_0400) begin n_fail++; $display("FAIL sim_first_out: got %0b/%h/%h expected 1/00000400/10000400", out_valid, out_pc, out_instr); end
  endtask

  task automatic test_withdraw();
    bit found;
    mem_req_ready = 1'b0;
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_req_valid) found = 1'b1;
      else tick();
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL wd_req timeout: got no request expected one"); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0600;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL wd_dropped: got %0b expected 0", mem_req_valid); end
    tick();
    n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_0600) begin n_fail++; $display("FAIL wd_reassert: got %0b/%h expected 1/00000600", mem_req_valid, mem_req_addr); end
    mem_req_ready = 1'b1;
    tick();
    n_checks++; if (req_log[req_log.size() - 1] !== 32'h0000_0600) begin n_fail++; $display("FAIL wd_accept: got %h expected 00000600", req_log[req_log.size() - 1]); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_0600) begin n_fail++; $display("FAIL wd_out: got %0b/%h expected 1/00000600", out_valid, out_pc); end
  endtask

  initial begin
    rst            = 1'b0;
    mem_req_ready  = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    out_ready      = 1'b0;
    rsp_pending    = 1'b0;
    rsp_hold       = 1'b0;
    rsp_addr       = 32'h0000_0000;
    test_reset();
    test_single_fetch();
    test_backpressure();
    test_redirect_wait();
    test_misaligned_wrap();
    test_simultaneous();
    test_withdraw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
